// File: rtl/am_mod_profile_scheduler.sv
// am_mod_profile_scheduler
// Steps the AM DDS DSB modulator through a table of (tuning word, amplitude,
// dwell) profiles. Each profile is held for max(dwell,1) clocks with no gap
// cycles. A sweep can run once or loop, and it can be aborted at any time.
// The outputs are muted whenever the scheduler is idle. The table can only be
// written while idle; a write attempted during a sweep is dropped and flagged.
module am_mod_profile_scheduler #(
   parameter int NPROF   = 8,
   parameter int AW      = 3,
   parameter int DWELL_W = 24
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_we,
   input  logic [AW-1:0]      cfg_addr,
   input  logic [31:0]        cfg_freq,
   input  logic [7:0]         cfg_amp,
   input  logic [DWELL_W-1:0] cfg_dwell,
   input  logic               start,
   input  logic               stop,
   input  logic               loop_en,
   input  logic [AW-1:0]      last_idx,
   output logic [31:0]        carrier_freq,
   output logic [7:0]         amplitude,
   output logic [AW-1:0]      prof_idx,
   output logic               prof_strobe,
   output logic               busy,
   output logic               done,
   output logic               cfg_err
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic [31:0]          carrier_q, carrier_d;
   logic [7:0]           amp_q, amp_d;
   logic [AW-1:0]        idx_q, idx_d;
   logic [AW-1:0]        last_q, last_d;
   logic [DWELL_W-1:0]   cnt_q, cnt_d;
   logic                 strobe_q, strobe_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;

   logic [31:0]          freq_tab_q  [NPROF];
   logic [7:0]           amp_tab_q   [NPROF];
   logic [DWELL_W-1:0]   dwell_tab_q [NPROF];

   logic                 tab_we;
   logic                 load_en;
   logic [AW-1:0]        load_idx;
   logic [DWELL_W-1:0]   load_dwell;

   // Table writes are only accepted while no sweep is running.
   assign tab_we = cfg_we && (state_q == IDLE);

   // Profile table storage; cleared by reset so a fresh sweep plays silence.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NPROF; i++) begin
            freq_tab_q[i]  <= '0;
            amp_tab_q[i]   <= '0;
            dwell_tab_q[i] <= '0;
         end
      end else if (tab_we) begin
         freq_tab_q[cfg_addr]  <= cfg_freq;
         amp_tab_q[cfg_addr]   <= cfg_amp;
         dwell_tab_q[cfg_addr] <= cfg_dwell;
      end
   end

   // Next-state logic for the sweep FSM. A single load path presents a new
   // profile; the table is read from current contents, so a write landing on
   // the same edge as a start does not affect the entry being loaded.
   always_comb begin
      state_d    = state_q;
      carrier_d  = carrier_q;
      amp_d      = amp_q;
      idx_d      = idx_q;
      last_d     = last_q;
      cnt_d      = cnt_q;
      strobe_d   = 1'b0;
      busy_d     = busy_q;
      done_d     = 1'b0;
      err_d      = cfg_we && (state_q == RUN);
      load_en    = 1'b0;
      load_idx   = '0;
      load_dwell = '0;

      case (state_q)
         IDLE: begin
            carrier_d = '0;
            amp_d     = '0;
            busy_d    = 1'b0;
            if (start && !stop) begin
               load_en  = 1'b1;
               load_idx = '0;
               last_d   = last_idx;
               busy_d   = 1'b1;
               state_d  = RUN;
            end
         end
         RUN: begin
            if (stop) begin
               state_d   = IDLE;
               carrier_d = '0;
               amp_d     = '0;
               busy_d    = 1'b0;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else if (idx_q != last_q) begin
               load_en  = 1'b1;
               load_idx = idx_q + 1'b1;
            end else if (loop_en) begin
               load_en  = 1'b1;
               load_idx = '0;
            end else begin
               state_d   = IDLE;
               carrier_d = '0;
               amp_d     = '0;
               busy_d    = 1'b0;
               done_d    = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (load_en) begin
         load_dwell = dwell_tab_q[load_idx];
         carrier_d  = freq_tab_q[load_idx];
         amp_d      = amp_tab_q[load_idx];
         idx_d      = load_idx;
         strobe_d   = 1'b1;
         cnt_d      = (load_dwell == '0) ? '0 : load_dwell - 1'b1;
      end
   end

   // State and registered outputs; reset mutes the modulator immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         carrier_q <= '0;
         amp_q     <= '0;
         idx_q     <= '0;
         last_q    <= '0;
         cnt_q     <= '0;
         strobe_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         carrier_q <= carrier_d;
         amp_q     <= amp_d;
         idx_q     <= idx_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
         strobe_q  <= strobe_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign carrier_freq = carrier_q;
   assign amplitude    = amp_q;
   assign prof_idx     = idx_q;
   assign prof_strobe  = strobe_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign cfg_err      = err_q;

endmodule

// File: tb/tb_am_mod_profile_scheduler.sv
// Directed bench for am_mod_profile_scheduler: one-shot, looped, aborted,
// rejected-write, zero-dwell and mid-sweep reset scenarios.
module tb_am_mod_profile_scheduler;

   logic        clk;
   logic        rst;
   logic        cfg_we;
   logic [2:0]  cfg_addr;
   logic [31:0] cfg_freq;
   logic [7:0]  cfg_amp;
   logic [23:0] cfg_dwell;
   logic        start;
   logic        stop;
   logic        loop_en;
   logic [2:0]  last_idx;
   logic [31:0] carrier_freq;
   logic [7:0]  amplitude;
   logic [2:0]  prof_idx;
   logic        prof_strobe;
   logic        busy;
   logic        done;
   logic        cfg_err;

   int assertCount;
   int failCount;

   // Expected three-entry table used by the sweep model below.
   logic [31:0] mF [3];
   logic [7:0]  mA [3];
   int          mD [3];

   am_mod_profile_scheduler #(.NPROF(8), .AW(3), .DWELL_W(24)) dut (
      .clk          (clk),
      .rst          (rst),
      .cfg_we       (cfg_we),
      .cfg_addr     (cfg_addr),
      .cfg_freq     (cfg_freq),
      .cfg_amp      (cfg_amp),
      .cfg_dwell    (cfg_dwell),
      .start        (start),
      .stop         (stop),
      .loop_en      (loop_en),
      .last_idx     (last_idx),
      .carrier_freq (carrier_freq),
      .amplitude    (amplitude),
      .prof_idx     (prof_idx),
      .prof_strobe  (prof_strobe),
      .busy         (busy),
      .done         (done),
      .cfg_err      (cfg_err)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Safety net so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic stepCycle();
      @(negedge clk);
   endtask

   task automatic applyStimulus(input logic st, input logic sp, input logic le, input logic [2:0] li);
      start    = st;
      stop     = sp;
      loop_en  = le;
      last_idx = li;
   endtask

   task automatic writeEntry(input logic [2:0] a, input logic [31:0] f, input logic [7:0] m, input logic [23:0] d);
      cfg_we    = 1'b1;
      cfg_addr  = a;
      cfg_freq  = f;
      cfg_amp   = m;
      cfg_dwell = d;
      stepCycle();
      cfg_we    = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] ef, input logic [7:0] ea,
                              input logic [2:0] ei, input logic es, input logic eb,
                              input logic ed, input logic ee);
      logic [46:0] obs;
      logic [46:0] expv;
      obs  = {carrier_freq, amplitude, prof_idx, prof_strobe, busy, done, cfg_err};
      expv = {ef, ea, ei, es, eb, ed, ee};
      assertCount++;
      assert (obs === expv) else begin
         failCount++;
         $error("[TB] FAIL %s: got freq=%h amp=%0d idx=%0d strb=%b busy=%b done=%b err=%b, expected freq=%h amp=%0d idx=%0d strb=%b busy=%b done=%b err=%b",
                tag, carrier_freq, amplitude, prof_idx, prof_strobe, busy, done, cfg_err,
                ef, ea, ei, es, eb, ed, ee);
      end
   endtask

   task automatic checkMuted(input string tag);
      logic [42:0] obs;
      obs = {carrier_freq, amplitude, prof_strobe, busy, done};
      assertCount++;
      assert (obs === 43'd0) else begin
         failCount++;
         $error("[TB] FAIL %s: got freq=%h amp=%0d strb=%b busy=%b done=%b, expected all zero",
                tag, carrier_freq, amplitude, prof_strobe, busy, done);
      end
   endtask

   // Expected outputs on cycle c (1 = first cycle after the start edge) of a
   // one-shot sweep over entries 0..2 of the model table.
   task automatic expectSweepCycle(input string tag, input int c, input logic ee);
      int e;
      int first;
      e     = 0;
      first = 1;
      while (e < 3 && c >= first + mD[e]) begin
         first += mD[e];
         e++;
      end
      if (e == 3)
         checkOutput(tag, 32'd0, 8'd0, 3'd2, 1'b0, 1'b0, 1'b1, ee);
      else
         checkOutput(tag, mF[e], mA[e], 3'(e), (c == first), 1'b1, 1'b0, ee);
   endtask

   task automatic loadModelDefault();
      mF[0] = 32'h0100_0000; mA[0] = 8'd200; mD[0] = 5;
      mF[1] = 32'h0200_0000; mA[1] = 8'd100; mD[1] = 3;
      mF[2] = 32'h0400_0000; mA[2] = 8'd50;  mD[2] = 1;
   endtask

   initial begin
      assertCount = 0;
      failCount   = 0;
      rst       = 1'b1;
      cfg_we    = 1'b0;
      cfg_addr  = '0;
      cfg_freq  = '0;
      cfg_amp   = '0;
      cfg_dwell = '0;
      applyStimulus(1'b0, 1'b0, 1'b0, 3'd0);
      loadModelDefault();

      stepCycle();
      checkOutput("reset", 32'd0, 8'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      stepCycle();

      $display("[TB] one-shot sweep");
      writeEntry(3'd0, 32'h0100_0000, 8'd200, 24'd5);
      writeEntry(3'd1, 32'h0200_0000, 8'd100, 24'd3);
      writeEntry(3'd2, 32'h0400_0000, 8'd50,  24'd1);
      checkOutput("idle_after_writes", 32'd0, 8'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 3'd2);
      stepCycle();
      for (int c = 1; c <= 10; c++) begin
         expectSweepCycle("oneshot", c, 1'b0);
         if (c == 3) start = 1'b0;
         stepCycle();
      end
      checkOutput("oneshot_idle", 32'd0, 8'd0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("[TB] looped sweep");
      applyStimulus(1'b1, 1'b0, 1'b1, 3'd2);
      stepCycle();
      start = 1'b0;
      for (int c = 1; c <= 27; c++) begin
         expectSweepCycle("loop", ((c - 1) % 9) + 1, 1'b0);
         if (c == 27) loop_en = 1'b0;
         stepCycle();
      end
      expectSweepCycle("loop_done", 10, 1'b0);
      stepCycle();
      checkOutput("loop_idle", 32'd0, 8'd0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("[TB] abort");
      applyStimulus(1'b1, 1'b0, 1'b0, 3'd2);
      stepCycle();
      for (int c = 1; c <= 8; c++) begin
         expectSweepCycle("abort_run", c, 1'b0);
         if (c == 1) start = 1'b0;
         if (c == 8) stop = 1'b1;
         stepCycle();
      end
      checkMuted("abort_mute");
      stop = 1'b0;
      for (int c = 0; c < 3; c++) begin
         stepCycle();
         checkMuted("abort_no_done");
      end

      $display("[TB] rejected write and start+write");
      applyStimulus(1'b1, 1'b0, 1'b0, 3'd2);
      stepCycle();
      for (int c = 1; c <= 10; c++) begin
         expectSweepCycle("busy_write", c, (c == 3));
         if (c == 1) start = 1'b0;
         if (c == 2) begin
            cfg_we    = 1'b1;
            cfg_addr  = 3'd1;
            cfg_freq  = 32'hDEAD_BEEF;
            cfg_amp   = 8'd7;
            cfg_dwell = 24'd9;
         end
         if (c == 3) cfg_we = 1'b0;
         stepCycle();
      end
      cfg_we    = 1'b1;
      cfg_addr  = 3'd0;
      cfg_freq  = 32'h0800_0000;
      cfg_amp   = 8'd25;
      cfg_dwell = 24'd2;
      applyStimulus(1'b1, 1'b0, 1'b0, 3'd2);
      stepCycle();
      cfg_we = 1'b0;
      start  = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         expectSweepCycle("old_entry0", c, 1'b0);
         stepCycle();
      end
      mF[0] = 32'h0800_0000; mA[0] = 8'd25; mD[0] = 2;
      applyStimulus(1'b1, 1'b0, 1'b0, 3'd2);
      stepCycle();
      start = 1'b0;
      for (int c = 1; c <= 7; c++) begin
         expectSweepCycle("new_entry0", c, 1'b0);
         stepCycle();
      end

      $display("[TB] zero dwell loop");
      writeEntry(3'd0, 32'h0000_0011, 8'd1, 24'd0);
      writeEntry(3'd1, 32'h0000_0022, 8'd2, 24'd0);
      applyStimulus(1'b1, 1'b0, 1'b1, 3'd1);
      stepCycle();
      start = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         if (((c - 1) % 2) == 0)
            checkOutput("dwell0", 32'h0000_0011, 8'd1, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
         else
            checkOutput("dwell0", 32'h0000_0022, 8'd2, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0);
         stepCycle();
      end
      stop = 1'b1;
      stepCycle();
      checkMuted("dwell0_stop");
      applyStimulus(1'b0, 1'b0, 1'b0, 3'd2);

      $display("[TB] reset mid-sweep");
      writeEntry(3'd0, 32'h0100_0000, 8'd200, 24'd5);
      writeEntry(3'd1, 32'h0200_0000, 8'd100, 24'd3);
      loadModelDefault();
      applyStimulus(1'b1, 1'b0, 1'b0, 3'd2);
      stepCycle();
      start = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         expectSweepCycle("pre_reset", c, 1'b0);
         stepCycle();
      end
      expectSweepCycle("pre_reset_e2", 9, 1'b0);
      #2 rst = 1'b1;
      #1 checkOutput("async_reset", 32'd0, 8'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      stepCycle();
      rst = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b0, 3'd0);
      stepCycle();
      start = 1'b0;
      checkOutput("empty_table_run", 32'd0, 8'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      stepCycle();
      checkOutput("empty_table_done", 32'd0, 8'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      stepCycle();
      checkOutput("empty_table_idle", 32'd0, 8'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
